// File: rtl/mips_cpu_pkg.sv
// Shared types and instruction-field constants for the multicycle MIPS core.
// state_t is also consumed by control_signal, so its encoding is fixed.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        FETCH         = 3'b000,
        DECODE        = 3'b001,
        EXECUTE       = 3'b010,
        MEMORY_ACCESS = 3'b011,
        WRITE_BACK    = 3'b100,
        HALT          = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_MULDIV,
        CLS_HILO,
        CLS_JUMP,
        CLS_NOP
    } instr_class_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes (IR[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier: opcode/func_code to instr_class_t.
// Anything not recognised is a NOP; no exception path exists in this core.
module mips_cpu_instr_class
    import mips_cpu_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   func_code,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = CLS_NOP;
        if (opcode == OP_SPECIAL) begin
            case (func_code)
                FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLTU,
                FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
                    instr_class = CLS_ALU;
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                    instr_class = CLS_MULDIV;
                FN_MTHI, FN_MTLO:
                    instr_class = CLS_HILO;
                FN_JR:
                    instr_class = CLS_JUMP;
                default:
                    instr_class = CLS_NOP;
            endcase
        end else begin
            case (opcode)
                OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
                    instr_class = CLS_ALU;
                OP_LW:   instr_class = CLS_LOAD;
                OP_SW:   instr_class = CLS_STORE;
                default: instr_class = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/mips_cpu_state_sequencer.sv
// Multicycle state sequencer: walks FETCH..WRITE_BACK per instruction class,
// stalls on waitrequest, holds EXECUTE for mul/div and halts when PC hits 0.
module mips_cpu_state_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        waitrequest,
    input  logic        pc_is_zero,
    output state_t      state,
    output logic        active,
    output logic        stall,
    output logic        instr_done,
    output logic [31:0] instr_count
);

    localparam logic [3:0] MD_LAST = 4'(MD_CYCLES - 1);

    instr_class_t instr_class;
    state_t       next_state;
    logic [3:0]   md_cnt;
    logic         md_hold;

    mips_cpu_instr_class u_instr_class (
        .opcode      (opcode),
        .func_code   (func_code),
        .instr_class (instr_class)
    );

    assign md_hold = (state == EXECUTE) && (instr_class == CLS_MULDIV) &&
                     (md_cnt != MD_LAST);

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                // HALT has priority over a pending bus stall
                if (pc_is_zero)       next_state = HALT;
                else if (waitrequest) next_state = FETCH;
                else                  next_state = DECODE;
            end
            DECODE: next_state = EXECUTE;
            EXECUTE: begin
                case (instr_class)
                    CLS_ALU:             next_state = WRITE_BACK;
                    CLS_LOAD, CLS_STORE: next_state = MEMORY_ACCESS;
                    CLS_MULDIV:          next_state = md_hold ? EXECUTE : FETCH;
                    default:             next_state = FETCH;
                endcase
            end
            MEMORY_ACCESS: begin
                if (waitrequest)                    next_state = MEMORY_ACCESS;
                else if (instr_class == CLS_LOAD)   next_state = WRITE_BACK;
                else                                next_state = FETCH;
            end
            WRITE_BACK: next_state = FETCH;
            HALT:       next_state = HALT;
            default:    next_state = FETCH;
        endcase
    end

    assign stall = ((state == FETCH) && !pc_is_zero && waitrequest) ||
                   ((state == MEMORY_ACCESS) && waitrequest) ||
                   md_hold;

    assign instr_done = (next_state == FETCH) && (state != FETCH) && (state != HALT);
    assign active     = (state != HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            md_cnt      <= 4'd0;
            instr_count <= 32'd0;
        end else begin
            state <= next_state;
            // EXECUTE is only ever entered from DECODE
            if (state == DECODE)
                md_cnt <= 4'd0;
            else if (md_hold)
                md_cnt <= md_cnt + 4'd1;
            if (instr_done)
                instr_count <= instr_count + 32'd1;
        end
    end

endmodule
